// File: rtl/ab_seq_fsm_pkg.sv
// ab_seq_fsm_pkg: shared state encoding and default symbol codes for the sequence recogniser.
package ab_seq_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_ARMED = 2'd2,
    S_HIT   = 2'd3
  } state_t;
  localparam logic [1:0] SYM_A = 2'b10;
  localparam logic [1:0] SYM_B = 2'b01;
endpackage

// File: rtl/ab_seq_fsm_if.sv
// ab_seq_fsm_if: symbol stream, configuration and match outputs of the recogniser.
interface ab_seq_fsm_if #(parameter int SYM_W = 2, parameter int LEN = 4, parameter int CNT_W = 8);
  logic [SYM_W-1:0]                 in_sym;
  logic                             in_valid;
  logic [LEN*SYM_W-1:0]             pattern;
  logic                             overlap;
  logic                             clr;
  logic                             y1;
  logic                             y0;
  logic [CNT_W-1:0]                 match_cnt;
  logic [ab_seq_pkg::STATE_W-1:0]   state_o;
  modport master (output in_sym, in_valid, pattern, overlap, clr,
                  input  y1, y0, match_cnt, state_o);
  modport slave  (input  in_sym, in_valid, pattern, overlap, clr,
                  output y1, y0, match_cnt, state_o);
endinterface

// File: rtl/ab_seq_hist.sv
// ab_seq_hist: shift history of the last LEN symbols (newest in slice 0) plus saturating fill count.
module ab_seq_hist #(parameter int SYM_W = 2, parameter int LEN = 4, localparam int FW = $clog2(LEN + 1)) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic                 flush,
  input  logic [SYM_W-1:0]     in_sym,
  output logic [LEN*SYM_W-1:0] cand,
  output logic [FW-1:0]        fill,
  output logic [FW-1:0]        fill_next
);
  logic [LEN*SYM_W-1:0] hist_q;
  logic [FW-1:0]        fill_q;
  always_comb begin
    cand      = {hist_q[(LEN-1)*SYM_W-1:0], in_sym};
    fill      = fill_q;
    fill_next = fill_q + FW'(fill_q != FW'(LEN));
  end
  // flush drops the whole window after a non-overlapping match
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clr || (in_valid && flush)) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (in_valid) begin
      hist_q <= cand;
      fill_q <= fill_next;
    end
  end
endmodule

// File: rtl/ab_seq_fsm.sv
// ab_seq_fsm: programmable LEN-symbol sequence recogniser with Mealy y1, Moore y0 and match counter.
// Define AB_SEQ_FSM_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module ab_seq_fsm import ab_seq_pkg::*; #(parameter int SYM_W = 2, parameter int LEN = 4, parameter int CNT_W = 8) (
  input logic         clk,
  input logic         reset,
  ab_seq_fsm_if.slave bus
);
  localparam int FW = $clog2(LEN + 1);
  logic [LEN*SYM_W-1:0] cand;
  logic [FW-1:0]        fill, fill_next;
  logic                 y1, y0_q;
  state_t               state_q, state_d;
  ab_seq_hist #(.SYM_W(SYM_W), .LEN(LEN)) u_hist (
    .clk       (clk),
    .reset     (reset),
    .clr       (bus.clr),
    .in_valid  (bus.in_valid),
    .flush     (y1 & ~bus.overlap),
    .in_sym    (bus.in_sym),
    .cand      (cand),
    .fill      (fill),
    .fill_next (fill_next)
  );
  always_comb begin
    y1      = bus.in_valid & ~bus.clr & (fill >= FW'(LEN - 1)) & (cand == bus.pattern);
    state_d = state_q;
    if (bus.clr)
      state_d = S_IDLE;
    else if (bus.in_valid)
      state_d = y1 ? (bus.overlap ? S_HIT : S_IDLE) :
                (fill_next == FW'(LEN)) ? S_ARMED :
                (fill_next != '0) ? S_FILL : S_IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      y0_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      y0_q    <= y1;
    end
  end
`ifdef AB_SEQ_FSM_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else if (bus.clr)
      cnt_q <= '0;
    else if (y1 && cnt_q != {CNT_W{1'b1}})
      cnt_q <= cnt_q + 1'b1;
  end
  assign bus.match_cnt = cnt_q;
`else
  assign bus.match_cnt = {CNT_W{1'b0}};
`endif
  assign bus.y1      = y1;
  assign bus.y0      = y0_q;
  assign bus.state_o = state_q;
endmodule

// File: tb/tb_ab_seq_fsm.sv
// tb_ab_seq_fsm: scoreboard bench; a CNT_W=8 and a CNT_W=2 instance share one directed symbol stream.
module tb_ab_seq_fsm;
  typedef struct packed {
    logic       y1;
    logic       y0;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic [1:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ab_seq_fsm_if #(.SYM_W(2), .LEN(4), .CNT_W(8)) m_if ();
  ab_seq_fsm_if #(.SYM_W(2), .LEN(4), .CNT_W(2)) s_if ();
  assign s_if.in_sym   = m_if.in_sym;
  assign s_if.in_valid = m_if.in_valid;
  assign s_if.pattern  = m_if.pattern;
  assign s_if.overlap  = m_if.overlap;
  assign s_if.clr      = m_if.clr;

  ab_seq_fsm #(.SYM_W(2), .LEN(4), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(m_if));
  ab_seq_fsm #(.SYM_W(2), .LEN(4), .CNT_W(2)) dut_sat (.clk(clk), .reset(reset), .bus(s_if));

  exp_t q[$];
  int   passed = 0;
  int   total = 0;

  logic [7:0] hist_m = '0;
  int         fill_m = 0;
  logic [1:0] st_m = '0;
  logic       y0_m = 1'b0;
  int         c8 = 0;
  int         c2 = 0;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("y1", int'(m_if.y1), int'(e.y1));
      chk("y0", int'(m_if.y0), int'(e.y0));
      chk("match_cnt", int'(m_if.match_cnt), int'(e.cnt));
      chk("sat_cnt", int'(s_if.match_cnt), int'(e.cnt2));
      chk("state_o", int'(m_if.state_o), int'(e.st));
      chk("sat_y1", int'(s_if.y1), int'(e.y1));
    end
  end

  // hy1 is the hand-derived Mealy output for this cycle; the model tracks the registered state
  task automatic step(input logic rs, input logic c, input logic v, input logic [1:0] s, input logic hy1);
    logic [7:0] cand_m;
    logic       y1m;
    exp_t       e;
    @(posedge clk);
    #1;
    reset = rs;
    m_if.clr = c;
    m_if.in_valid = v;
    m_if.in_sym = s;
    if (!rs) begin
      hist_m = '0; fill_m = 0; st_m = '0; y0_m = 1'b0; c8 = 0; c2 = 0;
    end
    cand_m = {hist_m[5:0], s};
    y1m = v && !c && rs && fill_m >= 3 && cand_m == m_if.pattern;
    e.y1 = hy1;
    e.y0 = y0_m;
`ifdef AB_SEQ_FSM_CNT_EN
    e.cnt = 8'(c8);
    e.cnt2 = 2'(c2);
`else
    e.cnt = '0;
    e.cnt2 = '0;
`endif
    e.st = st_m;
    q.push_back(e);
    if (rs) begin
      if (c) begin
        hist_m = '0; fill_m = 0; st_m = '0; y0_m = 1'b0; c8 = 0; c2 = 0;
      end else begin
        y0_m = y1m;
        if (v) begin
          if (y1m && !m_if.overlap) begin
            hist_m = '0; fill_m = 0; st_m = 2'd0;
          end else begin
            hist_m = cand_m;
            fill_m = (fill_m == 4) ? 4 : fill_m + 1;
            st_m = y1m ? 2'd3 : (fill_m == 4) ? 2'd2 : 2'd1;
          end
          if (y1m) begin
            c8 = (c8 == 255) ? 255 : c8 + 1;
            c2 = (c2 == 3) ? 3 : c2 + 1;
          end
        end
      end
    end
  endtask

  task automatic feed(input logic [1:0] s, input logic hy1);
    step(1'b1, 1'b0, 1'b1, s, hy1);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic setup(input logic [7:0] pat, input logic ov);
    m_if.pattern = pat;
    m_if.overlap = ov;
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    m_if.in_sym = '0;
    m_if.in_valid = 1'b0;
    m_if.pattern = 8'h55;
    m_if.overlap = 1'b1;
    m_if.clr = 1'b0;
    repeat (5) step(1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    repeat (2) idle();
    repeat (3) feed(2'b01, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    repeat (3) feed(2'b01, 1'b0);
    feed(2'b01, 1'b1);
    idle();

    setup(8'hD2, 1'b0);
    feed(2'b11, 1'b0); feed(2'b01, 1'b0); feed(2'b00, 1'b0); feed(2'b10, 1'b1);
    idle(); idle();

    setup(8'h55, 1'b1);
    repeat (3) feed(2'b01, 1'b0);
    repeat (3) feed(2'b01, 1'b1);
    idle(); idle();

    setup(8'h55, 1'b0);
    repeat (2) begin
      repeat (3) feed(2'b01, 1'b0);
      feed(2'b01, 1'b1);
    end
    idle();

    setup(8'hD2, 1'b0);
    feed(2'b11, 1'b0); feed(2'b01, 1'b0);
    repeat (3) idle();
    feed(2'b00, 1'b0); feed(2'b10, 1'b1);
    idle();

    setup(8'hD2, 1'b0);
    feed(2'b11, 1'b0); feed(2'b01, 1'b0);
    idle();
    step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
    idle();
    feed(2'b00, 1'b0); feed(2'b10, 1'b0);
    idle();

    setup(8'h55, 1'b1);
    repeat (3) feed(2'b01, 1'b0);
    repeat (7) feed(2'b01, 1'b1);
    idle();
    @(negedge clk);
`ifdef AB_SEQ_FSM_CNT_EN
    chk("final_cnt8", int'(m_if.match_cnt), 7);
    chk("final_cnt2", int'(s_if.match_cnt), 3);
`else
    chk("final_cnt8", int'(m_if.match_cnt), 0);
    chk("final_cnt2", int'(s_if.match_cnt), 0);
`endif
    chk("final_state", int'(m_if.state_o), 3);
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ab_seq_fsm.md
Name: ab_seq_fsm

Overview:
- Parametrised successor of the two-input (a,b) control FSM.
- Detects a programmable sequence of LEN symbols. Each symbol is SYM_W bits wide; {a,b} is the SYM_W=2 case.
- Provides a Mealy output y1 (combinational, same cycle), a Moore output y0 (registered, one cycle later), and a match counter.
- Used as a generic control/protocol recogniser inside lab datapaths.

Parameters:
- SYM_W, 2, bits per input symbol (bit1=a, bit0=b in the default configuration).
- LEN, 4, pattern length in symbols, minimum 2.
- CNT_W, 8, match counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_sym  in  SYM_W  input symbol.
- in_valid  in  1  in_sym is consumed this cycle.
- pattern  in  LEN*SYM_W  target sequence. Slice k (pattern[k*SYM_W +: SYM_W]) is the symbol expected k steps before the newest; slice 0 is the final symbol. Quasi-static.
- overlap  in  1  1 = history kept after a match (overlapping matches); 0 = history discarded after a match.
- clr  in  1  synchronous clear.
- y1  out  1  Mealy: the current valid symbol completes a match.
- y0  out  1  Moore: a match completed on the previous cycle.
- match_cnt  out  CNT_W  saturating count of matches.
- state_o  out  2  current FSM state encoding.

Behaviour:
- Async reset (reset=0), and clr=1 at a clock edge, both force: state=S_IDLE, fill=0, hist=0, y0=0, match_cnt=0.
- clr has priority over in_valid. A symbol presented with clr=1 is dropped and y1=0.
- Reset deasserting mid-sequence discards all partial history.
- hist holds the last LEN symbols, newest in the low slice. On in_valid: hist <= {hist minus top slice, in_sym}.
- fill counts 0..LEN and saturates at LEN.
- cand = shifted history including in_sym.
- y1 = in_valid & ~clr & (fill >= LEN-1) & (cand == pattern). Purely combinational; zero latency.
- y0 <= y1 registered. It is a one-cycle pulse per match. Back-to-back matches give y0 high on consecutive cycles.
- On a match:
  - overlap=1: hist updates normally; fill stays LEN.
  - overlap=0: fill <= 0 and hist <= 0, so the next match needs LEN fresh symbols.
- No in_valid: hist, fill and state hold. y1=0. y0 drops after one cycle.
- FSM states (2-bit): S_IDLE=0 (fill=0), S_FILL=1 (0<fill<LEN), S_ARMED=2 (fill=LEN, last valid symbol not a match), S_HIT=3 (last valid symbol was a match).
- FSM transitions on in_valid, evaluated in this order:
  1. Match: to S_HIT if overlap=1, else to S_IDLE.
  2. Else fill_next==LEN: to S_ARMED.
  3. Else fill_next>0: to S_FILL.
- S_HIT with no in_valid holds S_HIT. y0 still pulses only once.
- Changing overlap or pattern takes effect on the next comparison. No retroactive matches are produced.
- match_cnt increments when y1=1 and saturates at 2^CNT_W-1. A match arriving at saturation leaves the count unchanged and y1/y0 still pulse.

Optional Feature:
- Macro: AB_SEQ_FSM_CNT_EN.
- Defined: match_cnt is implemented as described.
- Undefined: the counter register is removed and match_cnt is tied to 0. All other behaviour is identical.

Decomposition:
- Shared package ab_seq_pkg holds:
  - state typedef/localparams S_IDLE, S_FILL, S_ARMED, S_HIT;
  - the 2-bit state width;
  - the default symbol encodings SYM_A=2'b10, SYM_B=2'b01.
- One natural sub-module: ab_seq_hist. It contains the shift history plus the fill counter and outputs cand and fill_next.
- The FSM, y0 register and counter stay in the top module.

Test Plan (SYM_W=2, LEN=4, CNT_W=8):
- Reset: hold reset=0 during valid symbols. Expect y0=y1=0, match_cnt=0, state_o=0. Release reset: state stays 0 until the first in_valid.
- Exact match: pattern=8'hD2, overlap=0. Feed 11,01,00,10 on consecutive cycles.
  - y1=1 in the 4th cycle only.
  - y0=1 the following cycle.
  - match_cnt=1, state_o returns to 0.
- Overlap: pattern=8'h55 (01 x4).
  - Feed 01 x6 with overlap=1: y1 on symbols 4,5,6; match_cnt=3; state_o=3.
  - Repeat after clr with overlap=0 and 01 x8: y1 only on symbols 4 and 8; match_cnt=2.
- Gaps and clr: pattern=8'hD2.
  - Feed 11,01, idle 3 cycles (in_valid=0), then 00,10: match on the 4th valid symbol.
  - Repeat with clr=1 asserted during the idle gap: no match; state_o=0 after clr.
- Saturation (CNT_W=2): pattern=8'h55, overlap=1, feed 01 x10. match_cnt stops at 3 while y1 keeps pulsing.
- Macro off (AB_SEQ_FSM_CNT_EN undefined): rerun the overlap scenario. y0/y1 timing is identical; match_cnt stays 0 throughout.
